// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hold/flush controller with multicycle stall counter and pending-jump latch
// Optional PIPE_CTRL_PERF_EN adds stall/flush performance counters.
module pipe_ctrl #(
  parameter int STAGES = 4,
  parameter int ADDR_W = 32,
  parameter int MC_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump_req_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_id_req_i,
  input  logic              mc_start_i,
  input  logic [MC_W-1:0]   mc_cycles_i,
  input  logic              bus_busy_i,
  output logic [STAGES-1:0] hold_o,
  output logic [STAGES-1:0] flush_o,
  output logic              jump_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              mc_busy_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  if (STAGES < 3) begin : g_bad_stages
    $error("pipe_ctrl: STAGES must be at least 3");
  end

  localparam logic [STAGES-1:0] FLUSH_JUMP = {{(STAGES-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    SEL_BUS,
    SEL_MC,
    SEL_JUMP,
    SEL_START,
    SEL_HOLD_ID,
    SEL_IDLE
  } sel_e;

  sel_e              sel;
  logic [MC_W-1:0]   mc_cnt;
  logic              pend;
  logic [ADDR_W-1:0] pend_addr;

  assign mc_busy_o = (mc_cnt != '0);

  always_comb begin
    sel = SEL_IDLE;
    if (bus_busy_i)                               sel = SEL_BUS;
    else if (mc_busy_o)                           sel = SEL_MC;
    else if (pend || jump_req_i)                  sel = SEL_JUMP;
    else if (mc_start_i && (mc_cycles_i != '0))   sel = SEL_START;
    else if (hold_id_req_i)                       sel = SEL_HOLD_ID;
  end

  // Reset value of flush_o marks every pipeline register invalid.
  always_comb begin
    hold_o      = '0;
    flush_o     = '0;
    jump_o      = 1'b0;
    jump_addr_o = '0;
    if (!rst_n) begin
      flush_o = FLUSH_JUMP;
    end else begin
      case (sel)
        SEL_BUS, SEL_MC, SEL_START: hold_o = '1;
        SEL_JUMP: begin
          jump_o      = 1'b1;
          flush_o     = FLUSH_JUMP;
          jump_addr_o = pend ? pend_addr : jump_addr_i;
        end
        SEL_HOLD_ID: begin
          hold_o[0]  = 1'b1;
          hold_o[1]  = 1'b1;
          flush_o[2] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_cnt    <= '0;
      pend      <= 1'b0;
      pend_addr <= '0;
    end else begin
      case (sel)
        SEL_BUS: begin
          if (jump_req_i) begin
            pend      <= 1'b1;
            pend_addr <= jump_addr_i;
          end
        end
        SEL_MC:    mc_cnt <= mc_cnt - MC_W'(1);
        SEL_JUMP: begin
          pend      <= 1'b0;
          pend_addr <= '0;
        end
        // Start cycle is itself a stall cycle, so only mc_cycles_i-1 remain.
        SEL_START: mc_cnt <= mc_cycles_i - MC_W'(1);
        default: ;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (hold_o[0]) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (jump_o)    flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - table-driven and sequence checks for pipe_ctrl (STAGES=4)
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_req_i;
  logic [31:0] jump_addr_i;
  logic        hold_id_req_i;
  logic        mc_start_i;
  logic [5:0]  mc_cycles_i;
  logic        bus_busy_i;
  logic [3:0]  hold_o;
  logic [3:0]  flush_o;
  logic        jump_o;
  logic [31:0] jump_addr_o;
  logic        mc_busy_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
  int          m_stall = 0;
  int          m_flush = 0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.STAGES(4), .ADDR_W(32), .MC_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i),
    .hold_id_req_i(hold_id_req_i), .mc_start_i(mc_start_i),
    .mc_cycles_i(mc_cycles_i), .bus_busy_i(bus_busy_i),
    .hold_o(hold_o), .flush_o(flush_o), .jump_o(jump_o),
    .jump_addr_o(jump_addr_o), .mc_busy_o(mc_busy_o)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  typedef struct {
    string       name;
    logic        jr;
    logic [31:0] ja;
    logic        hid;
    logic        ms;
    logic [5:0]  mc;
    logic        bb;
    logic [3:0]  eh;
    logic [3:0]  ef;
    logic        ej;
    logic [31:0] ea;
    logic        eb;
  } vec_t;

  vec_t vecs[14];

  task automatic drive(input logic jr, input logic [31:0] ja, input logic hid,
                       input logic ms, input logic [5:0] mc, input logic bb);
    jump_req_i    = jr;
    jump_addr_i   = ja;
    hold_id_req_i = hid;
    mc_start_i    = ms;
    mc_cycles_i   = mc;
    bus_busy_i    = bb;
  endtask

  task automatic step(input logic jr, input logic [31:0] ja, input logic hid,
                      input logic ms, input logic [5:0] mc, input logic bb);
    @(negedge clk);
    drive(jr, ja, hid, ms, mc, bb);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] eh, input logic [3:0] ef,
                     input logic ej, input logic [31:0] ea, input logic eb);
    checks++;
    if (hold_o !== eh || flush_o !== ef || jump_o !== ej || jump_addr_o !== ea || mc_busy_o !== eb) begin
      errors++;
      $display("FAIL %s: got hold=%b flush=%b jump=%b addr=%h busy=%b, want hold=%b flush=%b jump=%b addr=%h busy=%b",
               nm, hold_o, flush_o, jump_o, jump_addr_o, mc_busy_o, eh, ef, ej, ea, eb);
    end
`ifdef PIPE_CTRL_PERF_EN
    if (!rst_n) begin
      m_stall = 0;
      m_flush = 0;
    end
    checks++;
    if (stall_cnt_o !== 32'(m_stall) || flush_cnt_o !== 32'(m_flush)) begin
      errors++;
      $display("FAIL %s perf: got stall=%0d flush=%0d, want stall=%0d flush=%0d",
               nm, stall_cnt_o, flush_cnt_o, m_stall, m_flush);
    end
    if (rst_n) begin
      if (eh[0]) m_stall++;
      if (ej)    m_flush++;
    end
`endif
  endtask

  initial begin
    vecs[0]  = '{"idle",          0, 32'h0,        0, 0, 6'd0, 0, 4'b0000, 4'b0000, 0, 32'h0,        0};
    vecs[1]  = '{"jump_80",       1, 32'h80,       0, 0, 6'd0, 0, 4'b0000, 4'b1110, 1, 32'h80,       0};
    vecs[2]  = '{"jump_hi",       1, 32'hFFFFFFFC, 0, 0, 6'd0, 0, 4'b0000, 4'b1110, 1, 32'hFFFFFFFC, 0};
    vecs[3]  = '{"jump_over_mc",  1, 32'h10,       0, 1, 6'd3, 0, 4'b0000, 4'b1110, 1, 32'h10,       0};
    vecs[4]  = '{"jump_over_hid", 1, 32'h20,       1, 0, 6'd0, 0, 4'b0000, 4'b1110, 1, 32'h20,       0};
    vecs[5]  = '{"hold_id",       0, 32'h0,        1, 0, 6'd0, 0, 4'b0011, 4'b0100, 0, 32'h0,        0};
    vecs[6]  = '{"after_hold_id", 0, 32'h0,        0, 0, 6'd0, 0, 4'b0000, 4'b0000, 0, 32'h0,        0};
    vecs[7]  = '{"mc_zero",       0, 32'h0,        0, 1, 6'd0, 0, 4'b0000, 4'b0000, 0, 32'h0,        0};
    vecs[8]  = '{"mc_zero_hid",   0, 32'h0,        1, 1, 6'd0, 0, 4'b0011, 4'b0100, 0, 32'h0,        0};
    vecs[9]  = '{"mc_one",        0, 32'h0,        0, 1, 6'd1, 0, 4'b1111, 4'b0000, 0, 32'h0,        0};
    vecs[10] = '{"mc_one_hid",    0, 32'h0,        1, 1, 6'd1, 0, 4'b1111, 4'b0000, 0, 32'h0,        0};
    vecs[11] = '{"bus_only",      0, 32'h0,        1, 0, 6'd0, 1, 4'b1111, 4'b0000, 0, 32'h0,        0};
    vecs[12] = '{"bus_mc_start",  0, 32'h0,        0, 1, 6'd5, 1, 4'b1111, 4'b0000, 0, 32'h0,        0};
    vecs[13] = '{"after_bus_mc",  0, 32'h0,        0, 0, 6'd0, 0, 4'b0000, 4'b0000, 0, 32'h0,        0};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    chk("reset", 4'b0000, 4'b1110, 0, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_idle", 4'b0000, 4'b0000, 0, 32'h0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].jr, vecs[i].ja, vecs[i].hid, vecs[i].ms, vecs[i].mc, vecs[i].bb);
      chk(vecs[i].name, vecs[i].eh, vecs[i].ef, vecs[i].ej, vecs[i].ea, vecs[i].eb);
    end

    // Multicycle op of 3: start cycle plus two counted cycles, jumps ignored.
    step(0, 0, 0, 1, 6'd3, 0);  chk("mc3_start", 4'b1111, 4'b0000, 0, 32'h0, 0);
    step(1, 32'h44, 0, 0, 0, 0); chk("mc3_c1",   4'b1111, 4'b0000, 0, 32'h0, 1);
    step(1, 32'h48, 1, 1, 6'd2, 0); chk("mc3_c2", 4'b1111, 4'b0000, 0, 32'h0, 1);
    step(0, 0, 0, 0, 0, 0);      chk("mc3_done", 4'b0000, 4'b0000, 0, 32'h0, 0);

    // Redirect raised during a bus wait is replayed once the bus frees up.
    step(1, 32'h100, 0, 0, 0, 1); chk("bus_jump_a", 4'b1111, 4'b0000, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 1);       chk("bus_jump_b", 4'b1111, 4'b0000, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 0);       chk("pend_fire",  4'b0000, 4'b1110, 1, 32'h100, 0);
    step(0, 0, 0, 0, 0, 0);       chk("pend_clear", 4'b0000, 4'b0000, 0, 32'h0, 0);

    // Later request overwrites pending target; pending wins over a live request.
    step(1, 32'h200, 0, 0, 0, 1); chk("ovw_a",    4'b1111, 4'b0000, 0, 32'h0, 0);
    step(1, 32'h300, 0, 0, 0, 1); chk("ovw_b",    4'b1111, 4'b0000, 0, 32'h0, 0);
    step(1, 32'h400, 0, 0, 0, 0); chk("ovw_fire", 4'b0000, 4'b1110, 1, 32'h300, 0);
    step(0, 0, 0, 0, 0, 0);       chk("ovw_done", 4'b0000, 4'b0000, 0, 32'h0, 0);

    // Async reset with counter=5 and a pending jump discards both.
    step(0, 0, 0, 1, 6'd6, 0);    chk("rst_mc_start", 4'b1111, 4'b0000, 0, 32'h0, 0);
    step(1, 32'h55, 0, 0, 0, 1);  chk("rst_bus_jump", 4'b1111, 4'b0000, 0, 32'h0, 1);
    step(0, 0, 0, 0, 0, 0);       chk("rst_busy5",    4'b1111, 4'b0000, 0, 32'h0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 4'b0000, 4'b1110, 0, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release", 4'b0000, 4'b0000, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 0);       chk("rst_no_pend", 4'b0000, 4'b0000, 0, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Parametrised pipeline hold/flush controller for the in-order core. Arbitrates four sources each cycle:
- jump/branch redirect from ex
- load-use hold from id
- multicycle-op stall from ex
- external bus wait

It drives per-stage hold and flush vectors to pc_reg and every pipeline register (if_id, id_ex, ...). It also owns the multicycle stall counter and a pending-jump latch, so redirects raised during a bus wait are not lost.

Parameters:
STAGES, 4, number of state-holding stages: index 0 = pc_reg, 1..STAGES-1 = pipeline registers; index STAGES-1 feeds ex; legal range 3..8
ADDR_W, 32, instruction address width
MC_W, 6, width of multicycle cycle count

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
jump_req_i  input  1  ex requests redirect this cycle
jump_addr_i  input  ADDR_W  redirect target
hold_id_req_i  input  1  id load-use hazard, one-cycle bubble request
mc_start_i  input  1  ex launches multicycle op
mc_cycles_i  input  MC_W  total stall cycles for that op
bus_busy_i  input  1  external bus not ready, freeze whole pipe
hold_o  output  STAGES  1 = stage k keeps its current contents
flush_o  output  STAGES  1 = stage k loads NOP/invalid; bit 0 always 0
jump_o  output  1  pc_reg loads jump_addr_o
jump_addr_o  output  ADDR_W  redirect target to pc_reg
mc_busy_o  output  1  multicycle counter running

Behaviour:
Reset (rst_n low, asynchronous):
- Counter cleared; pending-jump flag and address cleared.
- Outputs: hold_o=0, flush_o={STAGES-1{1},1'b0}, jump_o=0, jump_addr_o=0, mc_busy_o=0.

Outputs are combinational from state and inputs, with zero-cycle latency. One case applies per cycle, in priority order:
1. bus_busy_i=1:
   - hold_o all ones, flush_o=0, jump_o=0.
   - If jump_req_i=1, set pend=1 and pend_addr=jump_addr_i; a later request overwrites.
   - Counter frozen; mc_start_i ignored.
2. mc_busy_o=1:
   - hold_o all ones, flush_o=0, jump_o=0.
   - Counter decrements by 1; mc_busy_o falls when the counter reaches 0.
   - jump_req_i, mc_start_i and hold_id_req_i are ignored.
3. pend=1 or jump_req_i=1:
   - jump_o=1, hold_o=0, flush_o[1..STAGES-1]=1.
   - jump_addr_o=pend_addr if pend, else jump_addr_i.
   - pend cleared at the clock edge.
   - Simultaneous mc_start_i is ignored, since a jump instruction cannot be a multicycle op.
4. mc_start_i=1 and mc_cycles_i!=0:
   - hold_o all ones this cycle.
   - Counter loads mc_cycles_i-1.
   - Total stall equals exactly mc_cycles_i cycles.
   - mc_cycles_i=0 is a no-op; mc_cycles_i=1 stalls the start cycle only.
5. hold_id_req_i=1: hold_o[0]=hold_o[1]=1, flush_o[2]=1, all other bits 0.
6. Otherwise: hold_o=0, flush_o=0, jump_o=0.

Rules that apply in every case:
- jump_addr_o=0 whenever jump_o=0.
- mc_busy_o = (counter!=0).
- The counter never underflows.
- Reset mid-stall or mid-pending discards all state immediately.
- STAGES<3 is a compile-time error.

Optional Feature:
PIPE_CTRL_PERF_EN:
- Defined: adds stall_cnt_o (32b) and flush_cnt_o (32b) outputs. stall_cnt_o increments each cycle hold_o[0]=1; flush_cnt_o increments each cycle jump_o=1. Both wrap modulo 2^32 and reset to 0.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- rst_n low, STAGES=4 -> hold_o=4'b0000, flush_o=4'b1110, jump_o=0, mc_busy_o=0; same values after release with idle inputs, except flush_o=0.
- jump_req_i=1, jump_addr_i=0x80 for one cycle -> same cycle jump_o=1, jump_addr_o=0x80, flush_o=4'b1110, hold_o=0.
- hold_id_req_i=1 -> hold_o=4'b0011, flush_o=4'b0100; next idle cycle all zeros.
- mc_start_i=1, mc_cycles_i=3 -> hold_o=4'b1111 for exactly 3 cycles (start +2); mc_busy_o=1 for the 2 cycles after start; jump_req_i=1 during them -> jump_o stays 0. mc_cycles_i=0 -> no hold.
- bus_busy_i=1 for 2 cycles with jump_req_i=1, addr 0x100 in the first -> hold_o=4'b1111, jump_o=0; first cycle bus_busy_i=0 with jump_req_i=0 -> jump_o=1, jump_addr_o=0x100; next cycle jump_o=0.
- Async reset asserted with counter=5 and pend=1 -> mc_busy_o=0 immediately; after release, no jump and no hold. With PIPE_CTRL_PERF_EN, the previous scenarios give stall_cnt_o and flush_cnt_o equal to the counted hold/jump cycles.
